// File: rtl/alu_arbiter_pkg.sv
// Shared core defines for the ALU arbiter: ALU op codes, datapath widths
// and the arbiter FSM state encodings.
package alu_arbiter_pkg;

   localparam int ALU_OP_W    = 4;
   localparam int WORD_DATA_W = 32;
   localparam int SHAMT_W     = $clog2(WORD_DATA_W);

   typedef logic [ALU_OP_W-1:0]    alu_op_t;
   typedef logic [WORD_DATA_W-1:0] word_t;

   localparam alu_op_t ALU_OP_AND = 4'd0;
   localparam alu_op_t ALU_OP_OR  = 4'd1;
   localparam alu_op_t ALU_OP_XOR = 4'd2;
   localparam alu_op_t ALU_OP_SLL = 4'd3;
   localparam alu_op_t ALU_OP_SRL = 4'd4;
   localparam alu_op_t ALU_OP_SRA = 4'd5;
   localparam alu_op_t ALU_OP_ADD = 4'd6;
   localparam alu_op_t ALU_OP_SUB = 4'd7;

   localparam logic [0:0] ARB_ST_EMPTY = 1'b0;
   localparam logic [0:0] ARB_ST_FULL  = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/result bus between the hardware threads, the arbiter and the
// result consumer.
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int REQ_NUM = 4,
   parameter int TAG_W   = 2
);
   logic [REQ_NUM-1:0]             req_valid;
   logic [REQ_NUM*ALU_OP_W-1:0]    req_op;
   logic [REQ_NUM*WORD_DATA_W-1:0] req_arg0;
   logic [REQ_NUM*WORD_DATA_W-1:0] req_arg1;
   logic [REQ_NUM-1:0]             req_ready;
   logic                           res_valid;
   logic [TAG_W-1:0]               res_tag;
   logic [WORD_DATA_W-1:0]         res_val;
   logic                           res_ready;
   logic [REQ_NUM-1:0]             flush;

   modport slave (
      input  req_valid, req_op, req_arg0, req_arg1, res_ready, flush,
      output req_ready, res_valid, res_tag, res_val
   );

   modport master (
      output req_valid, req_op, req_arg0, req_arg1, res_ready, flush,
      input  req_ready, res_valid, res_tag, res_val
   );
endinterface

// File: rtl/alu.sv
// Shared integer ALU: purely combinational, undefined op codes return 0.
module alu
   import alu_arbiter_pkg::*;
(
   input  alu_op_t op,
   input  word_t   arg0,
   input  word_t   arg1,
   output word_t   res
);
   always_comb begin
      res = '0;
      case (op)
         ALU_OP_AND: res = arg0 & arg1;
         ALU_OP_OR:  res = arg0 | arg1;
         ALU_OP_XOR: res = arg0 ^ arg1;
         ALU_OP_SLL: res = arg0 << arg1[SHAMT_W-1:0];
         ALU_OP_SRL: res = arg0 >> arg1[SHAMT_W-1:0];
         ALU_OP_SRA: res = word_t'($signed(arg0) >>> arg1[SHAMT_W-1:0]);
         ALU_OP_ADD: res = arg0 + arg1;
         ALU_OP_SUB: res = arg0 - arg1;
         default:    res = '0;
      endcase
   end
endmodule

// File: rtl/rr_pick.sv
// Priority picker: first requester found searching upward from ptr
// (wrapping), returned as a one-hot grant.
module rr_pick #(
   parameter int REQ_NUM = 4,
   parameter int TAG_W   = 2
) (
   input  logic [REQ_NUM-1:0] req,
   input  logic [TAG_W-1:0]   ptr,
   output logic [REQ_NUM-1:0] gnt
);
   logic             found;
   logic [TAG_W-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = TAG_W'((int'(ptr) + k) % REQ_NUM);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates REQ_NUM threads onto one ALU with a single registered result slot.
// Define ALU_ARB_RR_EN for round-robin selection; default is fixed priority.
//
// state | meaning
// EMPTY | no result held, grants allowed
// FULL  | result held in res_val/res_tag, refill only when consumer takes it
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int REQ_NUM = 4,
   parameter int TAG_W   = 2
) (
   input logic          clk,
   input logic          reset_,
   alu_arbiter_if.slave bus
);
   logic [0:0]         state_q, state_d;
   logic [TAG_W-1:0]   res_tag_q, res_tag_d;
   word_t              res_val_q, res_val_d;
   logic [TAG_W-1:0]   pick_ptr;
   logic               grant_en;
   logic               xfer;
   logic               flush_held;
   logic [REQ_NUM-1:0] req_mask, gnt, ready;
   logic [TAG_W-1:0]   gnt_idx;
   alu_op_t            gnt_op;
   word_t              gnt_a0, gnt_a1, alu_res;

   // reset_ gates the grant so nothing can transfer while held in reset
   always_comb begin
      grant_en   = reset_ && ((state_q == ARB_ST_EMPTY) || bus.res_ready);
      req_mask   = bus.req_valid & ~bus.flush;
      ready      = grant_en ? gnt : '0;
      xfer       = |ready;
      flush_held = bus.flush[res_tag_q];
   end

`ifdef ALU_ARB_RR_EN
   logic [TAG_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (gnt_idx == TAG_W'(REQ_NUM-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign pick_ptr = ptr_q;
`else
   assign pick_ptr = '0;
`endif

   rr_pick #(.REQ_NUM(REQ_NUM), .TAG_W(TAG_W)) u_rr_pick (
      .req (req_mask),
      .ptr (pick_ptr),
      .gnt (gnt)
   );

   always_comb begin
      gnt_idx = '0;
      gnt_op  = '0;
      gnt_a0  = '0;
      gnt_a1  = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (gnt[i]) begin
            gnt_idx = TAG_W'(i);
            gnt_op  = bus.req_op[i*ALU_OP_W +: ALU_OP_W];
            gnt_a0  = bus.req_arg0[i*WORD_DATA_W +: WORD_DATA_W];
            gnt_a1  = bus.req_arg1[i*WORD_DATA_W +: WORD_DATA_W];
         end
      end
   end

   alu u_alu (
      .op   (gnt_op),
      .arg0 (gnt_a0),
      .arg1 (gnt_a1),
      .res  (alu_res)
   );

   always_comb begin
      state_d   = state_q;
      res_tag_d = res_tag_q;
      res_val_d = res_val_q;
      if (xfer) begin
         state_d   = ARB_ST_FULL;
         res_tag_d = gnt_idx;
         res_val_d = alu_res;
      end else if ((state_q == ARB_ST_FULL) && (bus.res_ready || flush_held)) begin
         state_d = ARB_ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= ARB_ST_EMPTY;
         res_tag_q <= '0;
         res_val_q <= '0;
      end else begin
         state_q   <= state_d;
         res_tag_q <= res_tag_d;
         res_val_q <= res_val_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.res_valid = (state_q == ARB_ST_FULL);
   assign bus.res_tag   = res_tag_q;
   assign bus.res_val   = res_val_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a result scoreboard; expectations
// follow ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TW = 2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [31:0]   val;
   } exp_t;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   alu_arbiter_if #(.REQ_NUM(N), .TAG_W(TW)) bus ();
   alu_arbiter #(.REQ_NUM(N), .TAG_W(TW)) dut (.clk(clk), .reset_(reset_), .bus(bus));

   exp_t          sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   logic          m_full   = 1'b0;
   logic [TW-1:0] m_tag    = '0;
   logic [TW-1:0] m_ptr    = '0;
   logic [31:0]   m_val    = '0;

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a ^ b;
         4'd3:    return a << b[4:0];
         4'd4:    return a >> b[4:0];
         4'd5:    return $signed(a) >>> b[4:0];
         4'd6:    return a + b;
         4'd7:    return a - b;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      bus.req_op[i*4 +: 4]     = op;
      bus.req_arg0[i*32 +: 32] = a;
      bus.req_arg1[i*32 +: 32] = b;
   endtask

   // Called at posedge+1 with inputs already driven; returns at next posedge+1.
   task automatic cycle(input string lbl, input logic want_en, input logic [N-1:0] want);
      logic [N-1:0] mask, eg;
      logic         allow;
      int           pick, i;
      exp_t         e;
      #3;
      allow = !m_full || bus.res_ready;
      mask  = bus.req_valid & ~bus.flush;
      eg    = '0;
      pick  = -1;
      if (allow) begin
         for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
            i = (int'(m_ptr) + k) % N;
`else
            i = k;
`endif
            if (pick < 0 && mask[i]) pick = i;
         end
      end
      if (pick >= 0) eg[pick] = 1'b1;
      chk({lbl, ".req_ready"}, bus.req_ready, eg);
      if (want_en) chk({lbl, ".grant"}, bus.req_ready, want);
      if (pick >= 0) begin
         e.tag = TW'(pick);
         e.val = alu_ref(bus.req_op[pick*4 +: 4], bus.req_arg0[pick*32 +: 32],
                         bus.req_arg1[pick*32 +: 32]);
         sb.push_back(e);
         m_full = 1'b1;
         m_ptr  = TW'((pick + 1) % N);
      end else if (m_full && (bus.res_ready || bus.flush[m_tag])) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({lbl, ".res_valid"}, bus.res_valid, m_full);
      if (sb.size() > 0) begin
         e     = sb.pop_front();
         m_tag = e.tag;
         m_val = e.val;
      end
      chk({lbl, ".res_tag"}, bus.res_tag, m_tag);
      chk({lbl, ".res_val"}, bus.res_val, m_val);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] w;
      reset_        = 1'b0;
      bus.req_valid = 4'b1111;
      bus.flush     = '0;
      bus.res_ready = 1'b1;
      bus.req_op    = '0;
      bus.req_arg0  = '0;
      bus.req_arg1  = '0;
      #12;
      chk("rst.req_ready", bus.req_ready, 4'b0000);
      chk("rst.res_valid", bus.res_valid, 1'b0);
      chk("rst.res_tag", bus.res_tag, 2'd0);
      chk("rst.res_val", bus.res_val, 32'h0);
      @(posedge clk);
      #1;
      reset_ = 1'b1;

      // single request, ADD 5+7
      bus.req_valid = 4'b0001;
      set_slot(0, ALU_OP_ADD, 32'd5, 32'd7);
      cycle("single", 1'b1, 4'b0001);
      chk("single.val12", bus.res_val, 32'd12);
      chk("single.tag0", bus.res_tag, 2'd0);

      // grant requester 3 so the round-robin pointer sits at 0
      bus.req_valid = 4'b1000;
      set_slot(3, ALU_OP_SUB, 32'd3, 32'd10);
      cycle("prime", 1'b1, 4'b1000);
      chk("prime.val", bus.res_val, 32'hFFFF_FFF9);

      // contention
      bus.req_valid = 4'b1111;
      set_slot(0, ALU_OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
      set_slot(1, ALU_OP_OR,  32'h0000_00F0, 32'h0000_0F00);
      set_slot(2, ALU_OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_0000);
      set_slot(3, ALU_OP_SLL, 32'd1, 32'd31);
      for (int k = 0; k < 5; k++) begin
`ifdef ALU_ARB_RR_EN
         w = 4'b0001 << (k % 4);
`else
         w = 4'b0001;
`endif
         cycle($sformatf("cont%0d", k), 1'b1, w);
      end

      // backpressure: held result stays, no grant until res_ready
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b0010;
      set_slot(1, ALU_OP_SRL, 32'h8000_0000, 32'd31);
      for (int k = 0; k < 3; k++) begin
         cycle($sformatf("bp%0d", k), 1'b1, 4'b0000);
         chk("bp.hold", bus.res_val, 32'h0000_F000);
      end
      bus.res_ready = 1'b1;
      cycle("bp_release", 1'b1, 4'b0010);
      chk("bp_release.val", bus.res_val, 32'd1);

      // flush of the held result
      bus.req_valid = 4'b0100;
      set_slot(2, ALU_OP_SUB, 32'd0, 32'd1);
      cycle("get2", 1'b1, 4'b0100);
      bus.res_ready = 1'b0;
      bus.flush     = 4'b0100;
      cycle("flush", 1'b1, 4'b0000);
      chk("flush.valid", bus.res_valid, 1'b0);

      // flush masks a pending request
      bus.res_ready = 1'b1;
      bus.flush     = 4'b0001;
      bus.req_valid = 4'b0101;
      cycle("flmask", 1'b1, 4'b0100);
      bus.flush     = '0;

      // idle cycle must not move the pointer
      bus.req_valid = 4'b0000;
      cycle("idle", 1'b1, 4'b0000);
      bus.req_valid = 4'b1001;
`ifdef ALU_ARB_RR_EN
      w = 4'b1000;
`else
      w = 4'b0001;
`endif
      cycle("after_idle", 1'b1, w);

      // shifts, undefined op, full op sweep
      bus.req_valid = 4'b0001;
      set_slot(0, ALU_OP_SRA, 32'h8000_0000, 32'd4);
      cycle("sra", 1'b1, 4'b0001);
      chk("sra.val", bus.res_val, 32'hF800_0000);
      set_slot(0, 4'hF, 32'd1234, 32'd5678);
      cycle("undef", 1'b1, 4'b0001);
      chk("undef.val", bus.res_val, 32'h0);
      for (int op = 0; op < 16; op++) begin
         set_slot(0, 4'(op), 32'h8000_00F3, 32'h0000_0024);
         cycle($sformatf("op%0d", op), 1'b1, 4'b0001);
      end

      // reset in the middle of operation
      bus.req_valid = 4'b1111;
      set_slot(0, ALU_OP_ADD, 32'd100, 32'd23);
      #2;
      reset_ = 1'b0;
      #1;
      chk("midrst.res_valid", bus.res_valid, 1'b0);
      chk("midrst.res_val", bus.res_val, 32'h0);
      chk("midrst.res_tag", bus.res_tag, 2'd0);
      chk("midrst.req_ready", bus.req_ready, 4'b0000);
      m_full = 1'b0;
      m_tag  = '0;
      m_val  = '0;
      m_ptr  = '0;
      sb.delete();
      @(posedge clk);
      #1;
      reset_ = 1'b1;
      cycle("post_rst", 1'b1, 4'b0001);
      chk("post_rst.val", bus.res_val, 32'd123);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4, number of requesters (hardware threads) sharing one ALU.
REQ-002 SHALL have parameter TAG_W, default 2, requester-index width, equal to clog2(REQ_NUM).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  REQ_NUM  per-requester operation request.
REQ-006 Port req_op  input  REQ_NUM*ALU_OP_W  per-requester ALU op code, slot i at bits [i*ALU_OP_W +: ALU_OP_W].
REQ-007 Port req_arg0 / req_arg1  input  REQ_NUM*WORD_DATA_W  per-requester operands, packed like req_op.
REQ-008 Port req_ready  output  REQ_NUM  one-hot grant, combinational; at most one bit high.
REQ-009 Port res_valid  output  1  result register holds a valid result.
REQ-010 Port res_tag  output  TAG_W  index of the requester owning the result.
REQ-011 Port res_val  output  WORD_DATA_W  registered ALU result.
REQ-012 Port res_ready  input  1  consumer accepts the result this cycle.
REQ-013 Port flush  input  REQ_NUM  per-requester kill of its pending or held result.

Function
REQ-014 Transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 FSM SHALL have two states: EMPTY (no held result) and FULL (result held); reset enters EMPTY.
REQ-016 Grant SHALL be allowed when state is EMPTY, or FULL with res_ready high (same-cycle pipelined refill).
REQ-017 No grant SHALL be issued in FULL with res_ready low; the held result and res_tag SHALL stay stable.
REQ-018 Granted operands and op SHALL drive the internal ALU combinationally; its output is captured into res_val one cycle later (latency 1).
REQ-019 ALU op semantics SHALL be AND, OR, XOR, SLL, SRL, SRA, ADD, SUB on signed WORD_DATA_W operands; undefined op codes yield 0.
REQ-020 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on res_ready without transfer; FULL->FULL on res_ready with transfer, or on stall.
REQ-021 flush[res_tag] high while FULL SHALL drop the held result (FULL->EMPTY) regardless of res_ready.
REQ-022 req_ready[i] SHALL be forced low while flush[i] is high.
REQ-023 Requests with no req_valid bits set SHALL leave the priority pointer unchanged.
REQ-024 res_tag and res_val SHALL hold their last values when res_valid is low.

Reset
REQ-025 While reset_ is low: state EMPTY; res_valid 0; res_tag 0; res_val 0; priority pointer 0; req_ready all 0.
REQ-026 Reset asserted mid-operation SHALL discard any held result; no transfer completes in the reset cycle.

Configuration
REQ-027 With ALU_ARB_RR_EN defined, selection SHALL be round-robin: search starts at pointer; after a grant to i, pointer becomes (i+1) mod REQ_NUM, wrapping from REQ_NUM-1 to 0.
REQ-028 Without ALU_ARB_RR_EN, selection SHALL be fixed priority, lowest index wins; the pointer register is removed.

Structure
REQ-029 ALU_OP codes, ALU_OP_W (4) and WORD_DATA_W (32) SHALL come from the shared core defines; the FSM state encodings SHALL be placed in the same shared defines.
REQ-030 The arbiter SHALL instantiate the existing ALU as its only datapath.
REQ-031 Priority selection SHALL live in one sub-module, rr_pick, with inputs request vector and pointer and a one-hot grant output.

Verification
REQ-032 Single request: req_valid=0001, ADD 5,7, res_ready=1 -> req_ready=0001; next cycle res_valid=1, res_tag=0, res_val=12.
REQ-033 Contention (RR): req_valid=1111 held for 4 cycles, res_ready=1 -> grants 0001,0010,0100,1000 in order; then wraps to 0001.
REQ-034 Backpressure: FULL, res_ready=0 for 3 cycles with req_valid=0010 -> req_ready=0 throughout, res_val unchanged; res_ready=1 -> grant 0010 in that same cycle.
REQ-035 Flush: FULL with res_tag=2, flush=0100 -> next cycle res_valid=0; concurrent req_valid=0100 not granted.
REQ-036 SRA: arg0=0x80000000, arg1=4 -> res_val=0xF8000000; undefined op -> 0.
REQ-037 Reset mid-operation: FULL, then reset_ low -> res_valid=0, res_val=0 immediately; after release, the first grant goes to requester 0 with all requesting.
